// File: rtl/external_mem_responder_pkg.sv
// rtl/external_mem_responder_pkg.sv - shared types, LFSR polynomial and step function
// Purpose: request-queue entry layout and the 16-bit Galois LFSR used for latency.
// Entry field widths follow EXT_RESP_WIDTH / EXT_RESP_ADDR_WIDTH, which must
// match the WIDTH / ADDR_WIDTH parameters of external_mem_responder.
// Ports: none (package).

`ifndef EXT_RESP_WIDTH
`define EXT_RESP_WIDTH 32
`endif
`ifndef EXT_RESP_ADDR_WIDTH
`define EXT_RESP_ADDR_WIDTH 8
`endif

package external_mem_responder_pkg;

  localparam int ENTRY_WIDTH = `EXT_RESP_WIDTH;
  localparam int ENTRY_IDX_W = `EXT_RESP_ADDR_WIDTH - $clog2(`EXT_RESP_WIDTH / 8);

  localparam logic [15:0] LFSR_POLY = 16'hB400;

  typedef struct packed {
    logic                   is_wr;
    logic [ENTRY_IDX_W-1:0] idx;
    logic [ENTRY_WIDTH-1:0] wr_data;
    logic [ENTRY_WIDTH-1:0] wr_biten;
  } req_entry_t;

  // Right-shifting Galois step: feedback taps applied when the bit shifted out is 1.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    lfsr_next = {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/external_mem_responder_fifo.sv
// rtl/external_mem_responder_fifo.sv - synchronous request FIFO (ext_resp_fifo)
// Purpose: DEPTH-entry in-order queue of req_entry_t; head visible combinationally.
// Ports:
//   clk, rst          clock, synchronous active-low reset (flushes pointers/count)
//   push, push_entry  enqueue request (ignored when full)
//   pop               dequeue head (ignored when empty)
//   head_entry        entry at the read pointer
//   full, empty       derived from the registered count
//   count             number of stored entries

module ext_resp_fifo
  import external_mem_responder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  req_entry_t               push_entry,
  input  logic                     pop,
  output req_entry_t               head_entry,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  req_entry_t     store_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW:0]    count_q, count_d;
  logic           do_push, do_pop;

  assign full       = (count_q == (PW+1)'(DEPTH));
  assign empty      = (count_q == '0);
  assign count      = count_q;
  assign head_entry = store_q[rd_ptr_q];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    count_d  = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && do_push) store_q[wr_ptr_q] <= push_entry;
  end

endmodule

// File: rtl/external_mem_responder.sv
// rtl/external_mem_responder.sv - pipelined in-order req/ack memory responder
// Purpose: queues up to DEPTH requests, holds each head for MIN_LAT..MAX_LAT
// pseudo-random extra cycles and answers strictly in issue order.
// Optional feature macro: EXTERNAL_MEM_RESPONDER_ERR_EN adds rd_err/wr_err and ERR_IDX.
// Ports:
//   clk, rst           clock, synchronous active-low reset (mem contents kept)
//   req, req_is_wr     request strobe and direction (1 = write)
//   addr               byte address; word index = addr >> log2(WIDTH/8)
//   wr_data, wr_biten  write data and per-bit write enable
//   req_stall          queue full; request not taken this cycle
//   rd_ack, rd_data    one-cycle read response; rd_data is 0 outside rd_ack
//   wr_ack             one-cycle write response
//   rd_err, wr_err     (ERR_EN only) error flag qualifying the ack

module external_mem_responder
  import external_mem_responder_pkg::*;
#(
  parameter int          WIDTH      = `EXT_RESP_WIDTH,
  parameter int          ADDR_WIDTH = `EXT_RESP_ADDR_WIDTH,
  parameter int          DEPTH      = 4,
  parameter int          MIN_LAT    = 0,
  parameter int          MAX_LAT    = 3,
  parameter logic [15:0] SEED       = 16'hACE1
`ifdef EXTERNAL_MEM_RESPONDER_ERR_EN
  ,
  parameter int          ERR_IDX    = 0
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  req_is_wr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [WIDTH-1:0]      wr_biten,
  output logic                  req_stall,
  output logic                  rd_ack,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  wr_ack
`ifdef EXTERNAL_MEM_RESPONDER_ERR_EN
  ,
  output logic                  rd_err,
  output logic                  wr_err
`endif
);

  localparam int ADDR_SHIFT = $clog2(WIDTH / 8);
  localparam int IDX_W      = ADDR_WIDTH - ADDR_SHIFT;
  localparam int MEM_WORDS  = 2 ** IDX_W;
  localparam int LAT_RANGE  = MAX_LAT - MIN_LAT + 1;
  localparam int LAT_W      = (MAX_LAT > 0) ? $clog2(MAX_LAT + 1) : 1;
  localparam int CNT_W      = $clog2(DEPTH) + 1;

  req_entry_t        push_entry, head;
  logic              full, empty;
  logic [CNT_W-1:0]  count;
  logic              accept, fire, load, err_hit, mem_we;
  logic [WIDTH-1:0]  mem_wdata;

  logic [WIDTH-1:0]  mem_q [MEM_WORDS] = '{default: '0};

  logic [15:0]       lfsr_q, lfsr_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic              rd_ack_q, rd_ack_d;
  logic              wr_ack_q, wr_ack_d;
  logic [WIDTH-1:0]  rd_data_q, rd_data_d;
  logic              err_q, err_d;

  generate
    if (ADDR_SHIFT > 0) begin : g_lsb
      logic unused_addr_lsbs;
      assign unused_addr_lsbs = ^addr[ADDR_SHIFT-1:0];
    end
  endgenerate

  always_comb begin
    push_entry          = '0;
    push_entry.is_wr    = req_is_wr;
    push_entry.idx      = addr[ADDR_WIDTH-1:ADDR_SHIFT];
    push_entry.wr_data  = wr_data;
    push_entry.wr_biten = wr_biten;
  end

  ext_resp_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (accept),
    .push_entry (push_entry),
    .pop        (fire),
    .head_entry (head),
    .full       (full),
    .empty      (empty),
    .count      (count)
  );

  assign req_stall = full;
  assign accept    = req && !full;
  assign fire      = !empty && (lat_cnt_q == '0);
  // A new head appears on a push into an empty queue, or when a pop leaves
  // something behind (an older entry, or the entry pushed in the same cycle).
  assign load      = (accept && empty) || (fire && ((count > CNT_W'(1)) || accept));

`ifdef EXTERNAL_MEM_RESPONDER_ERR_EN
  assign err_hit = (head.idx == IDX_W'(ERR_IDX));
`else
  assign err_hit = 1'b0;
`endif

  always_comb begin
    lfsr_d    = lfsr_q;
    lat_cnt_d = lat_cnt_q;
    if (load) begin
      lat_cnt_d = LAT_W'(MIN_LAT + (int'(lfsr_q) % LAT_RANGE));
      lfsr_d    = lfsr_next(lfsr_q);
    end else if (!empty && lat_cnt_q != '0) begin
      lat_cnt_d = lat_cnt_q - 1'b1;
    end

    rd_ack_d  = fire && !head.is_wr;
    wr_ack_d  = fire && head.is_wr;
    err_d     = fire && err_hit;
    rd_data_d = '0;
    if (rd_ack_d && !err_hit) rd_data_d = mem_q[head.idx];

    mem_we    = wr_ack_d && !err_hit;
    mem_wdata = (mem_q[head.idx] & ~head.wr_biten) | (head.wr_data & head.wr_biten);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr_q    <= SEED;
      lat_cnt_q <= '0;
      rd_ack_q  <= 1'b0;
      wr_ack_q  <= 1'b0;
      rd_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      lfsr_q    <= lfsr_d;
      lat_cnt_q <= lat_cnt_d;
      rd_ack_q  <= rd_ack_d;
      wr_ack_q  <= wr_ack_d;
      rd_data_q <= rd_data_d;
      err_q     <= err_d;
    end
  end

  // Memory contents survive reset; only a fired write may change them.
  always_ff @(posedge clk) begin
    if (rst && mem_we) mem_q[head.idx] <= mem_wdata;
  end

  assign rd_ack  = rd_ack_q;
  assign wr_ack  = wr_ack_q;
  assign rd_data = rd_data_q;

`ifdef EXTERNAL_MEM_RESPONDER_ERR_EN
  assign rd_err = err_q && rd_ack_q;
  assign wr_err = err_q && wr_ack_q;
`else
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_external_mem_responder.sv
// tb/tb_external_mem_responder.sv - self-checking bench for external_mem_responder
// Instance 0: MIN=MAX=0, instance 1: MIN=MAX=3, instance 2: MIN=0 MAX=3.

module tb_external_mem_responder;

  logic        clk;
  logic        rst;
  logic        req       [3];
  logic        req_is_wr [3];
  logic [7:0]  addr      [3];
  logic [31:0] wr_data   [3];
  logic [31:0] wr_biten  [3];
  logic        req_stall [3];
  logic        rd_ack    [3];
  logic [31:0] rd_data   [3];
  logic        wr_ack    [3];
`ifdef EXTERNAL_MEM_RESPONDER_ERR_EN
  logic        rd_err    [3];
  logic        wr_err    [3];
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      external_mem_responder #(
        .WIDTH(32), .ADDR_WIDTH(8), .DEPTH(4),
        .MIN_LAT((g == 1) ? 3 : 0), .MAX_LAT((g == 0) ? 0 : 3), .SEED(16'hACE1)
`ifdef EXTERNAL_MEM_RESPONDER_ERR_EN
        , .ERR_IDX(5)
`endif
      ) u_dut (
        .clk(clk), .rst(rst), .req(req[g]), .req_is_wr(req_is_wr[g]), .addr(addr[g]),
        .wr_data(wr_data[g]), .wr_biten(wr_biten[g]), .req_stall(req_stall[g]),
        .rd_ack(rd_ack[g]), .rd_data(rd_data[g]), .wr_ack(wr_ack[g])
`ifdef EXTERNAL_MEM_RESPONDER_ERR_EN
        , .rd_err(rd_err[g]), .wr_err(wr_err[g])
`endif
      );
    end
  endgenerate

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Issue one request and wait for its ack. lat counts negedges after the accept edge.
  task automatic do_op(input int i, input bit wr, input int idx, input logic [31:0] d,
                       input logic [31:0] be, output int lat, output bit got_rd,
                       output bit got_wr, output bit got_err, output logic [31:0] data);
    int guard = 0;
    @(negedge clk);
    while (req_stall[i] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    req[i] = 1'b1; req_is_wr[i] = wr; addr[i] = 8'(idx << 2);
    wr_data[i] = d; wr_biten[i] = be;
    @(negedge clk);
    req[i] = 1'b0;
    lat = 1;
    got_rd = rd_ack[i]; got_wr = wr_ack[i]; data = rd_data[i]; got_err = 1'b0;
    while (!got_rd && !got_wr && lat < 40) begin
      @(negedge clk);
      lat++;
      got_rd = rd_ack[i]; got_wr = wr_ack[i]; data = rd_data[i];
    end
`ifdef EXTERNAL_MEM_RESPONDER_ERR_EN
    got_err = rd_err[i] | wr_err[i];
`endif
    if (!got_rd && !got_wr) lat = -1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      req[i] = 0; req_is_wr[i] = 0; addr[i] = 0; wr_data[i] = 0; wr_biten[i] = 0;
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (req_stall[i] !== 1'b0 || rd_ack[i] !== 1'b0 || wr_ack[i] !== 1'b0 || rd_data[i] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_state inst%0d: stall=%b rd_ack=%b wr_ack=%b rd_data=%h, required 0/0/0/0",
                 i, req_stall[i], rd_ack[i], wr_ack[i], rd_data[i]);
      end
    end
  endtask

  task automatic test_write_read();
    int lat; bit r, w, e; logic [31:0] d;
    do_op(0, 1, 3, 32'hDEADBEEF, 32'hFFFFFFFF, lat, r, w, e, d);
    n_checks++;
    if (lat !== 2 || w !== 1'b1 || r !== 1'b0) begin
      n_fail++; $display("FAIL wr_lat0: lat=%0d wr=%b rd=%b, required lat=2 wr=1 rd=0", lat, w, r);
    end
    do_op(0, 0, 3, 32'h0, 32'h0, lat, r, w, e, d);
    n_checks++;
    if (lat !== 2 || r !== 1'b1 || w !== 1'b0) begin
      n_fail++; $display("FAIL rd_lat0: lat=%0d rd=%b wr=%b, required lat=2 rd=1 wr=0", lat, r, w);
    end
    n_checks++;
    if (d !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL rd_data_full: got %h, required deadbeef", d);
    end
    @(negedge clk);
    n_checks++;
    if (rd_ack[0] !== 1'b0 || rd_data[0] !== 32'h0) begin
      n_fail++; $display("FAIL rd_data_idle: rd_ack=%b rd_data=%h, required 0/0", rd_ack[0], rd_data[0]);
    end
  endtask

  task automatic test_biten();
    int lat; bit r, w, e; logic [31:0] d;
    do_op(0, 1, 3, 32'h12345678, 32'h0000FFFF, lat, r, w, e, d);
    do_op(0, 0, 3, 32'h0, 32'h0, lat, r, w, e, d);
    n_checks++;
    if (d !== 32'hDEAD5678 || r !== 1'b1) begin
      n_fail++; $display("FAIL biten_merge: got %h rd=%b, required dead5678 rd=1", d, r);
    end
  endtask

  task automatic test_back_to_back();
    int acc[4]; int ackc[4]; logic [31:0] ackd[4]; int k = 0; int nack = 0;
    @(negedge clk);
    for (int g = 0; g < 12 && nack < 4; g++) begin
      if (rd_ack[0] && nack < 4) begin ackc[nack] = cyc; ackd[nack] = rd_data[0]; nack++; end
      if (k < 4) begin
        req[0] = 1; req_is_wr[0] = 0; addr[0] = 8'(3 << 2);
        if (!req_stall[0]) begin acc[k] = cyc + 1; k++; end
      end else req[0] = 0;
      @(negedge clk);
    end
    req[0] = 0;
    n_checks++;
    if (nack !== 4) begin n_fail++; $display("FAIL b2b_count: got %0d acks, required 4", nack); end
    for (int j = 0; j < nack; j++) begin
      n_checks++;
      if (ackc[j] !== acc[j] + 1 || ackd[j] !== 32'hDEAD5678) begin
        n_fail++; $display("FAIL b2b_ack%0d: cycle %0d data %h, required cycle %0d data dead5678",
                           j, ackc[j], ackd[j], acc[j] + 1);
      end
    end
  endtask

  task automatic test_stall_order();
    int lat; bit r, w, e; logic [31:0] d;
    int acc[6]; int ackc[6]; logic [31:0] ackd[6]; bit stalled[6];
    int k = 0; int nack = 0; int h;
    for (int j = 0; j < 6; j++) begin
      do_op(1, 1, 10 + j, 32'hA0000000 + j, 32'hFFFFFFFF, lat, r, w, e, d);
      n_checks++;
      if (lat !== 5 || w !== 1'b1) begin
        n_fail++; $display("FAIL lat3_write%0d: lat=%0d wr=%b, required lat=5 wr=1", j, lat, w);
      end
      stalled[j] = 0;
    end
    @(negedge clk);
    for (int g = 0; g < 120 && nack < 6; g++) begin
      if (rd_ack[1] && nack < 6) begin ackc[nack] = cyc; ackd[nack] = rd_data[1]; nack++; end
      if (k < 6) begin
        req[1] = 1; req_is_wr[1] = 0; addr[1] = 8'((10 + k) << 2);
        if (req_stall[1]) stalled[k] = 1;
        else begin acc[k] = cyc + 1; k++; end
      end else req[1] = 0;
      @(negedge clk);
    end
    req[1] = 0;
    n_checks++;
    if (nack !== 6) begin n_fail++; $display("FAIL stall_ack_count: got %0d, required 6", nack); end
    n_checks++;
    if (stalled[4] !== 1'b1 || stalled[0] | stalled[1] | stalled[2] | stalled[3]) begin
      n_fail++; $display("FAIL stall_5th: stalled=%b%b%b%b%b, required 1 only on 5th",
                         stalled[0], stalled[1], stalled[2], stalled[3], stalled[4]);
    end
    for (int j = 0; j < nack; j++) begin
      h = (j == 0 || acc[j] > ackc[j-1]) ? acc[j] : ackc[j-1];
      n_checks++;
      if (ackd[j] !== 32'hA0000000 + j || ackc[j] !== h + 4) begin
        n_fail++; $display("FAIL order_lat3_%0d: data %h cycle %0d, required %h cycle %0d",
                           j, ackd[j], ackc[j], 32'hA0000000 + j, h + 4);
      end
    end
  endtask

  typedef struct { bit wr; logic [31:0] data; int acc; } exp_t;

  task automatic test_random();
    logic [31:0] mdl [64];
    exp_t q[$]; exp_t ex;
    int accepted = 0; int prev_ack = -1000; int h; int idx;
    logic [31:0] dv, be; bit wr;
    for (int j = 0; j < 64; j++) mdl[j] = 32'h0;
    @(negedge clk);
    for (int g = 0; g < 20000 && (accepted < 1000 || q.size() > 0); g++) begin
      n_checks++;
      if (rd_ack[2] && wr_ack[2]) begin n_fail++; $display("FAIL both_acks at cycle %0d: rd=1 wr=1, required at most one", cyc); end
      if (rd_ack[2] || wr_ack[2]) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL spurious_ack at cycle %0d: ack with 0 outstanding, required none", cyc);
        end else begin
          ex = q.pop_front();
          h = (ex.acc > prev_ack) ? ex.acc : prev_ack;
          if (wr_ack[2] !== ex.wr || (!ex.wr && rd_data[2] !== ex.data) || cyc - h < 1 || cyc - h > 4) begin
            n_fail++; $display("FAIL rand_resp at cycle %0d: wr_ack=%b data=%h wait=%0d, required wr_ack=%b data=%h wait 1..4",
                               cyc, wr_ack[2], rd_data[2], cyc - h, ex.wr, ex.data);
          end
          prev_ack = cyc;
        end
      end
      n_checks++;
      if (req_stall[2] !== (q.size() == 4)) begin
        n_fail++; $display("FAIL rand_stall at cycle %0d: stall=%b outstanding=%0d, required stall iff 4",
                           cyc, req_stall[2], q.size());
      end
      if (accepted < 1000 && $urandom_range(0, 9) < 7) begin
        wr = 1'($urandom_range(0, 1)); idx = $urandom_range(0, 7); dv = $urandom;
        be = ($urandom_range(0, 1) == 1) ? 32'hFFFFFFFF : $urandom;
        req[2] = 1; req_is_wr[2] = wr; addr[2] = 8'(idx << 2); wr_data[2] = dv; wr_biten[2] = be;
        if (!req_stall[2]) begin
          accepted++;
          if (wr) mdl[idx] = (mdl[idx] & ~be) | (dv & be);
          ex.wr = wr; ex.data = wr ? 32'h0 : mdl[idx]; ex.acc = cyc + 1;
          q.push_back(ex);
        end
      end else req[2] = 0;
      @(negedge clk);
    end
    req[2] = 0;
    n_checks++;
    if (accepted !== 1000 || q.size() !== 0) begin
      n_fail++; $display("FAIL rand_drain: accepted=%0d outstanding=%0d, required 1000/0", accepted, q.size());
    end
  endtask

  task automatic test_reset_midflight();
    int lat; bit r, w, e; logic [31:0] d; bit any_ack = 0;
    @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      req[1] = 1; req_is_wr[1] = 1; addr[1] = 8'((20 + j) << 2);
      wr_data[1] = 32'h55550000 + j; wr_biten[1] = 32'hFFFFFFFF;
      @(negedge clk);
    end
    req[1] = 0; rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    n_checks++;
    if (req_stall[1] !== 1'b0) begin n_fail++; $display("FAIL stall_after_reset: got %b, required 0", req_stall[1]); end
    for (int g = 0; g < 12; g++) begin
      for (int i = 0; i < 3; i++) if (rd_ack[i] || wr_ack[i] || rd_data[i] !== 32'h0) any_ack = 1;
      @(negedge clk);
    end
    n_checks++;
    if (any_ack) begin n_fail++; $display("FAIL flushed_acks: got activity=1, required 0"); end
    for (int j = 0; j < 3; j++) begin
      do_op(1, 0, 20 + j, 32'h0, 32'h0, lat, r, w, e, d);
      n_checks++;
      if (r !== 1'b1 || d !== 32'h0) begin
        n_fail++; $display("FAIL mem_unchanged%0d: rd=%b data=%h, required rd=1 data=0", j, r, d);
      end
    end
  endtask

`ifdef EXTERNAL_MEM_RESPONDER_ERR_EN
  task automatic test_err();
    int lat; bit r, w, e; logic [31:0] d;
    do_op(0, 1, 5, 32'h1, 32'hFFFFFFFF, lat, r, w, e, d);
    n_checks++;
    if (w !== 1'b1 || e !== 1'b1) begin n_fail++; $display("FAIL wr_err: wr=%b err=%b, required 1/1", w, e); end
    do_op(0, 0, 5, 32'h0, 32'h0, lat, r, w, e, d);
    n_checks++;
    if (r !== 1'b1 || e !== 1'b1 || d !== 32'h0) begin
      n_fail++; $display("FAIL rd_err: rd=%b err=%b data=%h, required 1/1/0", r, e, d);
    end
    do_op(0, 0, 3, 32'h0, 32'h0, lat, r, w, e, d);
    n_checks++;
    if (e !== 1'b0 || d !== 32'hDEAD5678) begin
      n_fail++; $display("FAIL no_err_other: err=%b data=%h, required 0/dead5678", e, d);
    end
  endtask
`endif

  initial begin
    rst = 1'b0;
    test_reset();
    test_write_read();
    test_biten();
    test_back_to_back();
    test_stall_order();
    test_random();
    test_reset_midflight();
`ifdef EXTERNAL_MEM_RESPONDER_ERR_EN
    test_err();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
